// File: rtl/meter_pkg.sv
// ---------------------------------------------------------------------------
// meter_pkg
//
// Definitions shared by the parking meter core and its input conditioning
// stage:
//   - button index constants (bit positions inside a button vector)
//   - NUM_BTN, the number of physical push-buttons
//   - btn_vec_t, one bit per button
//   - BTN_PRIO_ORDER, the command priority order. The meter decodes
//     simultaneous commands in the same order.
//   - prio_grant(), a one-hot grant of the highest-priority request
// ---------------------------------------------------------------------------
package meter_pkg;

   localparam int NUM_BTN  = 6;

   localparam int BTN_ADD1 = 0;
   localparam int BTN_ADD2 = 1;
   localparam int BTN_ADD3 = 2;
   localparam int BTN_ADD4 = 3;
   localparam int BTN_RST1 = 4;
   localparam int BTN_RST2 = 5;

   typedef logic [NUM_BTN-1:0] btn_vec_t;
   typedef logic [2:0]         btn_idx_t;

   // Entry [0] is the highest priority: rst2 > rst1 > add4 > add3 > add2 > add1.
   localparam btn_idx_t [NUM_BTN-1:0] BTN_PRIO_ORDER = {
      3'd0,   // [5] add1 (lowest)
      3'd1,   // [4] add2
      3'd2,   // [3] add3
      3'd3,   // [2] add4
      3'd4,   // [1] rst1
      3'd5    // [0] rst2 (highest)
   };

   // Walk the priority list once. The first requesting button wins, and
   // every later entry is masked by 'found'.
   function automatic btn_vec_t prio_grant(input btn_vec_t req);
      btn_vec_t grant;
      logic     found;
      logic     hit;
      grant = {NUM_BTN{1'b0}};
      found = 1'b0;
      for (btn_idx_t i = 3'd0; i < 3'(NUM_BTN); i = i + 3'd1) begin
         hit                       = ~found & req[BTN_PRIO_ORDER[i]];
         grant[BTN_PRIO_ORDER[i]]  = hit;
         found                     = found | hit;
      end
      return grant;
   endfunction

endpackage : meter_pkg

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Debounces one raw asynchronous push-button level.
//   - A two-flop synchronizer brings the raw level into the clk domain.
//   - A run-length counter measures how long the synchronized level has
//     disagreed with the debounced level.
//   - The debounced level flips only after STABLE_CYCLES consecutive cycles
//     of disagreement. Any shorter disagreement restarts the count from zero.
//   - 'rise' is high for the one cycle after the debounced level goes 0->1.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   raw    in   raw button level (asynchronous)
//   level  out  debounced level (registered)
//   rise   out  single-cycle press indication, decoded from registers only
// ---------------------------------------------------------------------------
module btn_debounce
   import meter_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 500000,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             level_d_r;
   logic [CNT_W-1:0] cnt_r;
   logic             cnt_done_s;
   logic             differ_s;

   // Comparisons used by the counter and the level update.
   assign differ_s   = sync2_r ^ level_r;
   assign cnt_done_s = (cnt_r == CNT_W'(STABLE_CYCLES - 1));

   // Synchronizer, disagreement counter, debounced level and its one-cycle delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r   <= 1'b0;
         sync2_r   <= 1'b0;
         level_r   <= 1'b0;
         level_d_r <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
      end else begin
         sync1_r   <= raw;
         sync2_r   <= sync1_r;
         level_d_r <= level_r;
         if (!differ_s) begin
            // Agreement, including the end of a short glitch: restart the run.
            cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_done_s) begin
            // This is the STABLE_CYCLES-th consecutive cycle of disagreement.
            level_r <= sync2_r;
            cnt_r   <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   assign level = level_r;
   // A release (1->0) does not produce an event.
   assign rise  = level_r & ~level_d_r;

endmodule : btn_debounce

// File: rtl/meter_button_conditioner.sv
// ---------------------------------------------------------------------------
// meter_button_conditioner
//
// Input conditioning in front of the parking meter core. Each of the six
// raw buttons is synchronized and debounced. Every debounced press becomes a
// pending request. A fixed-priority arbiter issues at most one registered
// single-cycle command pulse per cycle. The meter therefore never sees two
// commands in the same cycle.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset. It clears every stage and
//                   drops queued events.
//   btn_raw    in   raw levels: [3:0] add1..add4, [4] rst1, [5] rst2
//   add1..add4 out  single-cycle coin-add command pulses (registered)
//   rst1,rst2  out  single-cycle preset pulses (registered)
//   btn_level  out  debounced levels, for debug LEDs
//   pending    out  accepted presses that have not been issued yet
// ---------------------------------------------------------------------------
module meter_button_conditioner
   import meter_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 500000,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic               add1,
   output logic               add2,
   output logic               add3,
   output logic               add4,
   output logic               rst1,
   output logic               rst2,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] pending
);

   btn_vec_t level_s;
   btn_vec_t rise_s;
   btn_vec_t grant_s;
   btn_vec_t pending_nxt_s;
   btn_vec_t pending_r;
   btn_vec_t pulse_r;

   // One independent debouncer per button.
   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
      ) u_debounce (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[g]),
         .level (level_s[g]),
         .rise  (rise_s[g])
      );
   end

   // Grant the highest-priority pending request. The granted bit is cleared
   // before new presses are merged in. If a press lands on a bit in the same
   // cycle that bit is granted, the bit stays set and the press is issued
   // later. A press on an already-pending bit merges into it.
   always_comb begin
      grant_s       = prio_grant(pending_r);
      pending_nxt_s = (pending_r & ~grant_s) | rise_s;
   end

   // Pending set and registered command pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= {NUM_BTN{1'b0}};
         pulse_r   <= {NUM_BTN{1'b0}};
      end else begin
         pending_r <= pending_nxt_s;
         pulse_r   <= grant_s;
      end
   end

   assign add1      = pulse_r[BTN_ADD1];
   assign add2      = pulse_r[BTN_ADD2];
   assign add3      = pulse_r[BTN_ADD3];
   assign add4      = pulse_r[BTN_ADD4];
   assign rst1      = pulse_r[BTN_RST1];
   assign rst2      = pulse_r[BTN_RST2];
   assign btn_level = level_s;
   assign pending   = pending_r;

endmodule : meter_button_conditioner

// File: tb/tb_meter_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_meter_button_conditioner
//
// Randomized and directed stimulus with STABLE_CYCLES = 4.
//
// The reference model states the behaviour directly:
//   - Each button keeps a window of its last S synchronized samples.
//   - The debounced level flips when every sample in the window disagrees
//     with the level.
//   - Presses join a pending set.
//   - Each cycle, the first pending button in the priority list is issued.
//
// The model pushes each expected pulse (cycle, button) into a scoreboard
// queue. A monitor process pops an entry and compares it whenever the DUT
// emits a pulse. Directed expectations are queued the same way and are
// compared by the monitor.
// ---------------------------------------------------------------------------
module tb_meter_button_conditioner;

   localparam int S  = 4;
   localparam int NB = 6;
   localparam int ORDER [NB] = '{5, 4, 3, 2, 1, 0};

   logic       clk;
   logic       rst;
   logic [5:0] btn_raw;
   logic       add1, add2, add3, add4, rst1, rst2;
   logic [5:0] btn_level;
   logic [5:0] pending;

   meter_button_conditioner #(.STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .add1      (add1),
      .add2      (add2),
      .add3      (add3),
      .add4      (add4),
      .rst1      (rst1),
      .rst2      (rst2),
      .btn_level (btn_level),
      .pending   (pending)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   logic [5:0]   m_s1    = 6'd0;
   logic [5:0]   m_s2    = 6'd0;
   logic [5:0]   m_level = 6'd0;
   logic [5:0]   m_rise  = 6'd0;
   logic [5:0]   m_pend  = 6'd0;
   logic [S-1:0] m_hist [NB];
   logic         m_in_rst = 1'b0;

   int    exp_cyc_q [$];
   int    exp_btn_q [$];
   string chk_name_q [$];
   int    chk_act_q [$];
   int    chk_exp_q [$];

   int pulse_cnt  [NB];
   int last_pulse [NB];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   task automatic model_step();
      logic         found;
      logic [S-1:0] h;
      logic         all_diff;
      logic         nl;
      int           b;
      cyc++;
      m_in_rst = rst;
      if (rst) begin
         m_s1 = 6'd0; m_s2 = 6'd0; m_level = 6'd0; m_rise = 6'd0; m_pend = 6'd0;
         for (int i = 0; i < NB; i++) m_hist[3'(i)] = '0;
      end else begin
         found = 1'b0;
         for (int i = 0; i < NB; i++) begin
            b = ORDER[3'(i)];
            if (!found && m_pend[3'(b)]) begin
               found = 1'b1;
               m_pend[3'(b)] = 1'b0;
               exp_cyc_q.push_back(cyc);
               exp_btn_q.push_back(b);
            end
         end
         m_pend = m_pend | m_rise;
         for (int i = 0; i < NB; i++) begin
            h = {m_hist[3'(i)][S-2:0], m_s2[3'(i)]};
            m_hist[3'(i)] = h;
            all_diff = m_level[3'(i)] ? (h == '0) : (&h);
            nl = all_diff ? ~m_level[3'(i)] : m_level[3'(i)];
            m_rise[3'(i)]  = nl & ~m_level[3'(i)];
            m_level[3'(i)] = nl;
         end
         m_s2 = m_s1;
         m_s1 = btn_raw;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic monitor_step();
      logic [5:0] p;
      int idx, ec, eb;
      p = {rst2, rst1, add4, add3, add2, add1};
      total++;
      if (pending !== m_pend) begin
         bad++;
         $display("FAIL pending cyc=%0d got %b want %b", cyc, pending, m_pend);
      end
      total++;
      if (btn_level !== m_level) begin
         bad++;
         $display("FAIL btn_level cyc=%0d got %b want %b", cyc, btn_level, m_level);
      end
      total++;
      if ($isunknown(p) || $countones(p) > 1) begin
         bad++;
         $display("FAIL onehot cyc=%0d got %b want at most one bit", cyc, p);
      end
      if (m_in_rst) begin
         total++;
         if (p !== 6'd0 || pending !== 6'd0 || btn_level !== 6'd0) begin
            bad++;
            $display("FAIL reset_zero cyc=%0d got p=%b pend=%b lvl=%b want all 0", cyc, p, pending, btn_level);
         end
      end
      if (p != 6'd0) begin
         idx = 0;
         for (int i = 0; i < NB; i++) if (p[3'(i)]) idx = i;
         pulse_cnt[3'(idx)]  = pulse_cnt[3'(idx)] + 1;
         last_pulse[3'(idx)] = cyc;
         total++;
         if (exp_cyc_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse cyc=%0d got btn %0d want none", cyc, idx);
         end else begin
            ec = exp_cyc_q.pop_front();
            eb = exp_btn_q.pop_front();
            if (ec != cyc || eb != idx) begin
               bad++;
               $display("FAIL pulse cyc=%0d got btn %0d@%0d want btn %0d@%0d", cyc, idx, cyc, eb, ec);
            end
         end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
         total++;
         bad++;
         ec = exp_cyc_q.pop_front();
         eb = exp_btn_q.pop_front();
         $display("FAIL missed_pulse cyc=%0d got none want btn %0d@%0d", cyc, eb, ec);
      end
      while (chk_name_q.size() > 0) begin
         string nm;
         int    a, e;
         nm = chk_name_q.pop_front();
         a  = chk_act_q.pop_front();
         e  = chk_exp_q.pop_front();
         total++;
         if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NB; i++) begin
         pulse_cnt[3'(i)]  = 0;
         last_pulse[3'(i)] = -1;
      end
      forever begin
         @(negedge clk);
         monitor_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_eq(input string name, input int act, input int exp);
      chk_name_q.push_back(name);
      chk_act_q.push_back(act);
      chk_exp_q.push_back(exp);
   endtask

   initial begin
      int t, r;
      int b0, b1, b2, b3, b4, b5;
      rst     = 1'b1;
      btn_raw = 6'($urandom);

      // 1. reset with random inputs
      for (int i = 0; i < 3; i++) begin
         btn_raw = 6'($urandom);
         tick(1);
      end
      btn_raw = 6'd0;
      rst     = 1'b0;
      tick(10);

      // 2. clean press on add2
      b1 = pulse_cnt[1];
      btn_raw[1] = 1'b1;
      t = cyc;
      tick(100);
      expect_eq("clean_count", pulse_cnt[1] - b1, 1);
      expect_eq("clean_latency", last_pulse[1] - (t + 1), 7);
      expect_eq("clean_level", int'(btn_level[1]), 1);
      btn_raw[1] = 1'b0;
      tick(20);
      expect_eq("clean_no_repeat", pulse_cnt[1] - b1, 1);

      // 3. bouncing add1
      b0 = pulse_cnt[0];
      for (int i = 0; i < 10; i++) begin
         btn_raw[0] = (i % 2 == 0);
         tick(2);
      end
      expect_eq("bounce_quiet", pulse_cnt[0] - b0, 0);
      btn_raw[0] = 1'b1;
      t = cyc;
      tick(30);
      expect_eq("bounce_count", pulse_cnt[0] - b0, 1);
      expect_eq("bounce_latency", last_pulse[0] - (t + 1), 7);
      btn_raw[0] = 1'b0;
      tick(20);

      // 4. simultaneous add1, add3, rst2
      b0 = pulse_cnt[0]; b2 = pulse_cnt[2]; b5 = pulse_cnt[5];
      btn_raw = 6'b100101;
      t = cyc;
      tick(7);
      expect_eq("simul_pend0", int'(pending), 6'b100101);
      tick(1);
      expect_eq("simul_pend1", int'(pending), 6'b000101);
      tick(1);
      expect_eq("simul_pend2", int'(pending), 6'b000001);
      tick(1);
      expect_eq("simul_pend3", int'(pending), 6'b000000);
      tick(2);
      expect_eq("simul_rst2_cnt", pulse_cnt[5] - b5, 1);
      expect_eq("simul_add3_cnt", pulse_cnt[2] - b2, 1);
      expect_eq("simul_add1_cnt", pulse_cnt[0] - b0, 1);
      expect_eq("simul_rst2_at", last_pulse[5] - t, 8);
      expect_eq("simul_add3_at", last_pulse[2] - t, 9);
      expect_eq("simul_add1_at", last_pulse[0] - t, 10);
      btn_raw = 6'd0;
      tick(20);

      // 5. release and re-press rst1, then a short release glitch
      b4 = pulse_cnt[4];
      btn_raw[4] = 1'b1; tick(20);
      btn_raw[4] = 1'b0; tick(10);
      btn_raw[4] = 1'b1; tick(20);
      btn_raw[4] = 1'b0; tick(20);
      expect_eq("repress_count", pulse_cnt[4] - b4, 2);
      b4 = pulse_cnt[4];
      btn_raw[4] = 1'b1; tick(20);
      btn_raw[4] = 1'b0; tick(3);
      btn_raw[4] = 1'b1; tick(20);
      btn_raw[4] = 1'b0; tick(20);
      expect_eq("glitch_count", pulse_cnt[4] - b4, 1);

      // 6. reset while add1/add2 are pending and add4 is held
      b0 = pulse_cnt[0]; b1 = pulse_cnt[1]; b3 = pulse_cnt[3];
      btn_raw = 6'b000011;
      t = cyc;
      tick(2);
      btn_raw[3] = 1'b1;
      tick(5);
      expect_eq("midrst_pend", int'(pending), 6'b000011);
      rst = 1'b1;
      btn_raw[1:0] = 2'b00;
      tick(3);
      rst = 1'b0;
      r = cyc;
      tick(12);
      expect_eq("midrst_add1", pulse_cnt[0] - b0, 0);
      expect_eq("midrst_add2", pulse_cnt[1] - b1, 0);
      expect_eq("midrst_add4", pulse_cnt[3] - b3, 1);
      expect_eq("midrst_add4_at", last_pulse[3] - (r + 1), 7);
      btn_raw = 6'd0;
      tick(20);

      // random phase
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            tick($urandom_range(1, 3));
            rst = 1'b0;
         end
         btn_raw = btn_raw ^ 6'($urandom & $urandom & $urandom);
         tick($urandom_range(1, 14));
      end

      btn_raw = 6'd0;
      tick(40);
      expect_eq("drain_empty", exp_cyc_q.size(), 0);
      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_meter_button_conditioner
